mem_stage: RTL and testbench

Memory-access stage of the 5-stage RV32I pipeline. Sits directly downstream of the EX/MEM pipeline register and upstream of MEM/WB. It passes ALU results through, and performs loads and stores over the shared byte-wide memory port. It holds the pipeline with a stall request for as many cycles as the byte-serial access takes.

---
 rtl/mem_stage_pkg.sv | 46 ++++
 rtl/load_ext.sv | 21 ++
 rtl/mem_stage.sv | 132 +++++++++++++
 tb/tb_mem_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the EX/MEM register and the memory-access stage.
// Opcode encodings, reset constants, FSM states and memory-op decode helpers.
package mem_stage_pkg;

  localparam int ALU_OP_W = 8;

  localparam logic [ALU_OP_W-1:0] ALU_NOP_OP = 8'h00;
  localparam logic [ALU_OP_W-1:0] ALU_LB_OP  = 8'hE0;
  localparam logic [ALU_OP_W-1:0] ALU_LH_OP  = 8'hE1;
  localparam logic [ALU_OP_W-1:0] ALU_LW_OP  = 8'hE3;
  localparam logic [ALU_OP_W-1:0] ALU_LBU_OP = 8'hE4;
  localparam logic [ALU_OP_W-1:0] ALU_LHU_OP = 8'hE5;
  localparam logic [ALU_OP_W-1:0] ALU_SB_OP  = 8'hE8;
  localparam logic [ALU_OP_W-1:0] ALU_SH_OP  = 8'hE9;
  localparam logic [ALU_OP_W-1:0] ALU_SW_OP  = 8'hEB;

  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic [4:0]  NopRegAddr = 5'b00000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  function automatic logic is_load(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_LB_OP) || (op == ALU_LH_OP) || (op == ALU_LW_OP) ||
           (op == ALU_LBU_OP) || (op == ALU_LHU_OP);
  endfunction

  function automatic logic is_store(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_SB_OP) || (op == ALU_SH_OP) || (op == ALU_SW_OP);
  endfunction

  // Zero for non-memory ops.
  function automatic logic [2:0] byte_count(input logic [ALU_OP_W-1:0] op);
    case (op)
      ALU_LB_OP, ALU_LBU_OP, ALU_SB_OP: return 3'd1;
      ALU_LH_OP, ALU_LHU_OP, ALU_SH_OP: return 3'd2;
      ALU_LW_OP, ALU_SW_OP:             return 3'd4;
      default:                          return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_ext.sv
// Sign/zero extension of the assembled load buffer according to the load opcode.
module load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0]         buf_i,
  input  logic [ALU_OP_W-1:0] aluop_i,
  output logic [31:0]         data_o
);

  always_comb begin
    data_o = buf_i;
    case (aluop_i)
      ALU_LB_OP:  data_o = {{24{buf_i[7]}}, buf_i[7:0]};
      ALU_LBU_OP: data_o = {24'h000000, buf_i[7:0]};
      ALU_LH_OP:  data_o = {{16{buf_i[15]}}, buf_i[15:0]};
      ALU_LHU_OP: data_o = {16'h0000, buf_i[15:0]};
      default:    data_o = buf_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: ALU passthrough, byte-serial loads/stores on the shared port.
// Stalls the pipeline until the access completes; read data lands one cycle after grant.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [ALU_OP_W-1:0] aluop_MEM_i,
  input  logic                wreg_MEM_i,
  input  logic [4:0]          waddr_MEM_i,
  input  logic [31:0]         alurslt_MEM_i,
  input  logic [31:0]         SdataBoffset_MEM_i,
  output logic                wreg_WB_o,
  output logic [4:0]          waddr_WB_o,
  output logic [31:0]         wdata_WB_o,
  output logic                stallreq_MEM_o,
  output logic                mem_req_o,
  input  logic                mem_gnt_i,
  output logic [31:0]         mem_a_o,
  output logic                mem_wr_o,
  output logic [7:0]          mem_dout_o,
  input  logic [7:0]          mem_din_i
);

  mem_state_e  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        issued_q, issued_d;
  logic [1:0]  slot_q, slot_d;
  logic [31:0] buf_q, buf_d;

  logic        ld, st, mem_op, last;
  logic [2:0]  nbytes;
  logic [31:0] ld_data;
  logic        req, stall, wreg;
  logic [31:0] wdata;

  assign ld     = is_load(aluop_MEM_i);
  assign st     = is_store(aluop_MEM_i);
  assign mem_op = ld | st;
  assign nbytes = byte_count(aluop_MEM_i);
  assign last   = ({1'b0, cnt_q} == (nbytes - 3'd1));

  load_ext u_load_ext (
    .buf_i   (buf_q),
    .aluop_i (aluop_MEM_i),
    .data_o  (ld_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 2'd0;
      issued_q <= 1'b0;
      slot_q   <= 2'd0;
      buf_q    <= ZeroWord;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      issued_q <= issued_d;
      slot_q   <= slot_d;
      buf_q    <= buf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    issued_d = 1'b0;
    slot_d   = slot_q;
    buf_d    = buf_q;
    req      = 1'b0;
    stall    = 1'b0;
    wreg     = 1'b0;
    wdata    = ZeroWord;

    // Read byte from the previous granted cycle, independent of this cycle's grant.
    if (issued_q) buf_d[{slot_q, 3'b000} +: 8] = mem_din_i;

    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          req     = 1'b1;
          stall   = 1'b1;
          state_d = ST_XFER;
        end else begin
          wreg  = wreg_MEM_i;
          wdata = alurslt_MEM_i;
        end
      end
      ST_XFER: begin
        req   = 1'b1;
        stall = 1'b1;
      end
      ST_WAIT: begin
        stall   = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (ld) begin
          wreg  = wreg_MEM_i;
          wdata = ld_data;
        end
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
        buf_d   = ZeroWord;
      end
      default: state_d = ST_IDLE;
    endcase

    if (req && mem_gnt_i) begin
      issued_d = ld;
      slot_d   = cnt_q;
      if (last) begin
        state_d = ld ? ST_WAIT : ST_DONE;
        cnt_d   = 2'd0;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  // Reset forces every output low immediately, whatever EX/MEM presents.
  assign mem_req_o      = rst & req;
  assign mem_wr_o       = rst & req & st;
  assign mem_a_o        = (rst && req) ? (alurslt_MEM_i + {30'd0, cnt_q}) : ZeroWord;
  assign mem_dout_o     = (rst && req) ? SdataBoffset_MEM_i[{cnt_q, 3'b000} +: 8] : 8'h00;
  assign stallreq_MEM_o = rst & stall;
  assign wreg_WB_o      = rst & wreg;
  assign wdata_WB_o     = rst ? wdata : ZeroWord;
  assign waddr_WB_o     = rst ? waddr_MEM_i : NopRegAddr;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a 4-byte read model around a per-test base address.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam logic [ALU_OP_W-1:0] ADD_OP = 8'h20;

  logic                clk;
  logic                rst;
  logic [ALU_OP_W-1:0] aluop;
  logic                wreg_in;
  logic [4:0]          waddr_in;
  logic [31:0]         alurslt;
  logic [31:0]         sdata;
  logic                wreg_WB_o;
  logic [4:0]          waddr_WB_o;
  logic [31:0]         wdata_WB_o;
  logic                stallreq_MEM_o;
  logic                mem_req_o;
  logic                mem_gnt_i;
  logic [31:0]         mem_a_o;
  logic                mem_wr_o;
  logic [7:0]          mem_dout_o;
  logic [7:0]          mem_din_i;

  int checks = 0;
  int errors = 0;
  logic [31:0] base;
  logic [7:0]  mem_bytes [4];
  logic [7:0]  sw_d [5];
  logic [31:0] sw_a [5];

  mem_stage dut (
    .clk                (clk),
    .rst                (rst),
    .aluop_MEM_i        (aluop),
    .wreg_MEM_i         (wreg_in),
    .waddr_MEM_i        (waddr_in),
    .alurslt_MEM_i      (alurslt),
    .SdataBoffset_MEM_i (sdata),
    .wreg_WB_o          (wreg_WB_o),
    .waddr_WB_o         (waddr_WB_o),
    .wdata_WB_o         (wdata_WB_o),
    .stallreq_MEM_o     (stallreq_MEM_o),
    .mem_req_o          (mem_req_o),
    .mem_gnt_i          (mem_gnt_i),
    .mem_a_o            (mem_a_o),
    .mem_wr_o           (mem_wr_o),
    .mem_dout_o         (mem_dout_o),
    .mem_din_i          (mem_din_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; a granted read returns its byte during the next cycle.
  task automatic tick();
    logic        rd;
    logic [31:0] off;
    rd  = mem_req_o && mem_gnt_i && !mem_wr_o;
    off = mem_a_o - base;
    @(posedge clk);
    #1;
    mem_din_i = rd ? mem_bytes[off[1:0]] : 8'hA5;
  endtask

  task automatic do_load(input string tag, input logic [ALU_OP_W-1:0] op,
                         input logic gnt0, input logic [31:0] exp_data, input int exp_stall);
    int n;
    n = 0;
    aluop = op; alurslt = base; wreg_in = 1'b1; waddr_in = 5'd9; mem_gnt_i = gnt0;
    #2;
    while (stallreq_MEM_o && n < 16) begin
      n++;
      tick();
      mem_gnt_i = 1'b1;
      #2;
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    chk({tag, "_wdata"}, wdata_WB_o, exp_data);
    chk({tag, "_wreg"}, {31'd0, wreg_WB_o}, 32'd1);
    tick();
    aluop = ALU_NOP_OP;
  endtask

  initial begin
    rst = 1'b0; aluop = ALU_LW_OP; wreg_in = 1'b1; waddr_in = 5'd3;
    alurslt = 32'h0000_0100; sdata = 32'h0; mem_gnt_i = 1'b1; mem_din_i = 8'h00;
    base = 32'h0; mem_bytes = '{8'h00, 8'h00, 8'h00, 8'h00};
    #2;
    chk("rst_req",   {31'd0, mem_req_o},      32'd0);
    chk("rst_stall", {31'd0, stallreq_MEM_o}, 32'd0);
    chk("rst_addr",  mem_a_o,                 32'd0);
    chk("rst_wdata", wdata_WB_o,              32'd0);
    chk("rst_waddr", {27'd0, waddr_WB_o},     32'd0);
    @(posedge clk); #1;
    aluop = ALU_NOP_OP;
    rst = 1'b1;

    // ALU passthrough
    aluop = ADD_OP; alurslt = 32'h1234_5678; waddr_in = 5'd5; wreg_in = 1'b1; mem_gnt_i = 1'b0;
    #2;
    chk("add_wdata", wdata_WB_o,              32'h1234_5678);
    chk("add_wreg",  {31'd0, wreg_WB_o},      32'd1);
    chk("add_waddr", {27'd0, waddr_WB_o},     32'd5);
    chk("add_stall", {31'd0, stallreq_MEM_o}, 32'd0);
    chk("add_req",   {31'd0, mem_req_o},      32'd0);
    tick();

    // LW, grant always high
    base = 32'h0000_0100; mem_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    aluop = ALU_LW_OP; alurslt = 32'h0000_0100; waddr_in = 5'd7; mem_gnt_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk($sformatf("lw_addr%0d", c), mem_a_o, 32'h0000_0100 + 32'(c));
      chk($sformatf("lw_stall%0d", c), {31'd0, stallreq_MEM_o}, 32'd1);
      chk($sformatf("lw_wr%0d", c), {31'd0, mem_wr_o}, 32'd0);
      tick();
    end
    #2;
    chk("lw_wait_req",   {31'd0, mem_req_o},      32'd0);
    chk("lw_wait_stall", {31'd0, stallreq_MEM_o}, 32'd1);
    chk("lw_wait_wreg",  {31'd0, wreg_WB_o},      32'd0);
    tick();
    #2;
    chk("lw_done_stall", {31'd0, stallreq_MEM_o}, 32'd0);
    chk("lw_done_wdata", wdata_WB_o,              32'h4433_2211);
    chk("lw_done_waddr", {27'd0, waddr_WB_o},     32'd7);
    chk("lw_done_wreg",  {31'd0, wreg_WB_o},      32'd1);
    tick();
    aluop = ALU_NOP_OP;

    // Extension variants
    base = 32'h0000_0300; mem_bytes = '{8'h80, 8'h00, 8'h00, 8'h00};
    do_load("lb",  ALU_LB_OP,  1'b1, 32'hFFFF_FF80, 2);
    do_load("lbu", ALU_LBU_OP, 1'b1, 32'h0000_0080, 2);
    do_load("lb_gnt_late", ALU_LB_OP, 1'b0, 32'hFFFF_FF80, 3);
    base = 32'h0000_0302; mem_bytes = '{8'hFE, 8'hFF, 8'h00, 8'h00};
    do_load("lh",  ALU_LH_OP,  1'b1, 32'hFFFF_FFFE, 3);
    do_load("lhu", ALU_LHU_OP, 1'b1, 32'h0000_FFFE, 3);

    // SB granted in the entry cycle goes straight to DONE
    aluop = ALU_SB_OP; alurslt = 32'h0000_0040; sdata = 32'h0000_0077; mem_gnt_i = 1'b1;
    #2;
    chk("sb_stall", {31'd0, stallreq_MEM_o}, 32'd1);
    chk("sb_dout",  {24'd0, mem_dout_o},     32'h77);
    chk("sb_wr",    {31'd0, mem_wr_o},       32'd1);
    tick();
    #2;
    chk("sb_done_stall", {31'd0, stallreq_MEM_o}, 32'd0);
    chk("sb_done_wreg",  {31'd0, wreg_WB_o},      32'd0);
    tick();
    aluop = ALU_NOP_OP;

    // SW with the grant withheld in the first cycle
    sw_d = '{8'hEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    sw_a = '{32'h200, 32'h200, 32'h201, 32'h202, 32'h203};
    aluop = ALU_SW_OP; alurslt = 32'h0000_0200; sdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 5; c++) begin
      mem_gnt_i = (c != 0);
      #2;
      chk($sformatf("sw_dout%0d", c), {24'd0, mem_dout_o}, {24'd0, sw_d[c]});
      chk($sformatf("sw_addr%0d", c), mem_a_o, sw_a[c]);
      chk($sformatf("sw_wr%0d", c), {31'd0, mem_wr_o}, 32'd1);
      chk($sformatf("sw_stall%0d", c), {31'd0, stallreq_MEM_o}, 32'd1);
      tick();
    end
    #2;
    chk("sw_done_stall", {31'd0, stallreq_MEM_o}, 32'd0);
    chk("sw_done_wreg",  {31'd0, wreg_WB_o},      32'd0);
    chk("sw_done_req",   {31'd0, mem_req_o},      32'd0);
    tick();
    aluop = ALU_NOP_OP;

    // SH address wrap
    aluop = ALU_SH_OP; alurslt = 32'hFFFF_FFFF; sdata = 32'h1234_A55A; mem_gnt_i = 1'b1;
    #2;
    chk("sh_addr0", mem_a_o, 32'hFFFF_FFFF);
    chk("sh_dout0", {24'd0, mem_dout_o}, 32'h5A);
    tick();
    #2;
    chk("sh_addr1", mem_a_o, 32'h0000_0000);
    chk("sh_dout1", {24'd0, mem_dout_o}, 32'hA5);
    tick();
    #2;
    chk("sh_done_stall", {31'd0, stallreq_MEM_o}, 32'd0);
    tick();
    aluop = ALU_NOP_OP;

    // Reset in cycle 2 of an LW
    base = 32'h0000_0100; mem_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    aluop = ALU_LW_OP; alurslt = 32'h0000_0100; waddr_in = 5'd7; mem_gnt_i = 1'b1;
    #2; tick();
    #2; tick();
    #2;
    chk("pre_rst_addr", mem_a_o, 32'h0000_0102);
    rst = 1'b0;
    #1;
    chk("mid_rst_req",   {31'd0, mem_req_o},      32'd0);
    chk("mid_rst_stall", {31'd0, stallreq_MEM_o}, 32'd0);
    chk("mid_rst_addr",  mem_a_o,                 32'd0);
    chk("mid_rst_wr",    {31'd0, mem_wr_o},       32'd0);
    chk("mid_rst_waddr", {27'd0, waddr_WB_o},     32'd0);
    aluop = ALU_NOP_OP; alurslt = 32'hCAFE_0000;
    tick();
    rst = 1'b1;
    #2;
    chk("post_rst_req",   {31'd0, mem_req_o},      32'd0);
    chk("post_rst_stall", {31'd0, stallreq_MEM_o}, 32'd0);
    chk("post_rst_wdata", wdata_WB_o,              32'hCAFE_0000);
    tick();

    base = 32'h0000_0500; mem_bytes = '{8'h9C, 8'h00, 8'h00, 8'h00};
    do_load("lbu_after_rst", ALU_LBU_OP, 1'b1, 32'h0000_009C, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
